// File: rtl/btb_defs.sv
// Shared BTB definitions: predictor state encoding, entry layout, table geometry.
package btb_defs;

  localparam int unsigned NUM_SETS = 8;
  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned TAG_W    = 27;
  localparam int unsigned ENTRY_W  = 64;
  localparam int unsigned SET_W    = 2 * ENTRY_W;

  // Entry field bit positions
  localparam int unsigned VALID_BIT = 63;
  localparam int unsigned TAG_MSB   = 62;
  localparam int unsigned TAG_LSB   = 36;
  localparam int unsigned TGT_MSB   = 35;
  localparam int unsigned TGT_LSB   = 4;
  localparam int unsigned STATE_MSB = 3;
  localparam int unsigned STATE_LSB = 2;

  // 2-bit predictor state; MSB set means predict taken
  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b11,
    STRONG_TAKEN     = 2'b10
  } bp_state_e;

  typedef enum logic {
    FSM_IDLE,
    FSM_FLUSH
  } fsm_state_e;

  // Packed to match the bit positions above
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    bp_state_e        state;
    logic [1:0]       spare;
  } btb_entry_t;

endpackage

// File: rtl/btb_state_next.sv
// 2-bit saturating predictor counter: (state, taken) -> next state.
module btb_state_next
  import btb_defs::*;
(
  input  bp_state_e i_state,
  input  logic      i_taken,
  output bp_state_e o_state
);

  // Step toward strong-taken on taken, toward strong-not-taken otherwise
  always_comb begin
    o_state = i_state;
    if (i_taken) begin
      case (i_state)
        STRONG_NOT_TAKEN: o_state = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   o_state = WEAK_TAKEN;
        WEAK_TAKEN:       o_state = STRONG_TAKEN;
        default:          o_state = STRONG_TAKEN;
      endcase
    end else begin
      case (i_state)
        STRONG_TAKEN:     o_state = WEAK_TAKEN;
        WEAK_TAKEN:       o_state = WEAK_NOT_TAKEN;
        WEAK_NOT_TAKEN:   o_state = STRONG_NOT_TAKEN;
        default:          o_state = STRONG_NOT_TAKEN;
      endcase
    end
  end

endmodule

// File: rtl/btb_table.sv
// BTB storage and update engine: 8 sets x 2 ways, per-set LRU, one-stage
// pipelined resolution update, and a set-per-cycle invalidate-all sequencer.
// Optional macro BTB_WRITE_BYPASS_EN forwards the pending update to read_set/lru.
module btb_table
  import btb_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  read_index,
  output logic [SET_W-1:0]    read_set,
  output logic [NUM_SETS-1:0] lru,
  input  logic                lookup_valid,
  input  logic                next_LRU_read,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [31:0]         upd_target,
  input  logic                upd_taken,
  input  logic                flush_req,
  output logic                busy
);

  btb_entry_t          r_way1 [NUM_SETS];
  btb_entry_t          r_way2 [NUM_SETS];
  logic [NUM_SETS-1:0] r_lru;

  fsm_state_e          r_fsm;
  fsm_state_e          w_fsm_nxt;
  logic [INDEX_W-1:0]  r_flush_cnt;

  logic                r_upd_v;
  logic [31:2]         r_upd_pc;
  logic [31:0]         r_upd_tgt;
  logic                r_upd_taken;

  logic [INDEX_W-1:0]  w_upd_idx;
  logic [TAG_W-1:0]    w_upd_tag;
  btb_entry_t          w_cur1, w_cur2, w_new1, w_new2, w_alloc;
  logic                w_hit1, w_hit2, w_commit, w_idle;
  logic                w_wr1, w_wr2, w_lru_we, w_lru_bit, w_victim;
  bp_state_e           w_hit_state, w_state_nxt;
  btb_entry_t          w_rd1, w_rd2;
  logic [NUM_SETS-1:0] w_lru_out;
  logic                w_unused_pc_lsb;

  assign w_unused_pc_lsb = ^upd_pc[1:0];
  assign w_idle    = (r_fsm == FSM_IDLE);
  assign w_upd_idx = r_upd_pc[INDEX_W+1:2];
  assign w_upd_tag = r_upd_pc[31:INDEX_W+2];
  assign w_cur1    = r_way1[w_upd_idx];
  assign w_cur2    = r_way2[w_upd_idx];
  assign w_hit1    = w_cur1.valid && (w_cur1.tag == w_upd_tag);
  assign w_hit2    = w_cur2.valid && (w_cur2.tag == w_upd_tag);
  assign w_hit_state = w_hit1 ? w_cur1.state : w_cur2.state;
  assign w_commit  = r_upd_v && w_idle;

  btb_state_next u_state_next (
    .i_state (w_hit_state),
    .i_taken (r_upd_taken),
    .o_state (w_state_nxt)
  );

  // Resolve the pending update against the array: hit step, allocate, or nothing
  always_comb begin
    w_new1    = w_cur1;
    w_new2    = w_cur2;
    w_wr1     = 1'b0;
    w_wr2     = 1'b0;
    w_lru_we  = 1'b0;
    w_lru_bit = r_lru[w_upd_idx];
    w_victim  = 1'b0;
    w_alloc   = '{valid: 1'b1, tag: w_upd_tag, target: r_upd_tgt,
                  state: WEAK_TAKEN, spare: 2'b00};
    if (w_commit) begin
      if (w_hit1) begin
        w_new1.state = w_state_nxt;
        if (r_upd_taken) w_new1.target = r_upd_tgt;
        w_wr1     = 1'b1;
        w_lru_we  = 1'b1;
        w_lru_bit = 1'b0;
      end else if (w_hit2) begin
        w_new2.state = w_state_nxt;
        if (r_upd_taken) w_new2.target = r_upd_tgt;
        w_wr2     = 1'b1;
        w_lru_we  = 1'b1;
        w_lru_bit = 1'b1;
      end else if (r_upd_taken) begin
        if (!w_cur1.valid)      w_victim = 1'b0;
        else if (!w_cur2.valid) w_victim = 1'b1;
        else                    w_victim = ~r_lru[w_upd_idx];
        if (w_victim) begin
          w_new2 = w_alloc;
          w_wr2  = 1'b1;
        end else begin
          w_new1 = w_alloc;
          w_wr1  = 1'b1;
        end
        w_lru_we  = 1'b1;
        w_lru_bit = w_victim;
      end
    end
  end

  // Sequencer next state: leave FLUSH after the last set is cleared
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      FSM_IDLE:  if (flush_req) w_fsm_nxt = FSM_FLUSH;
      FSM_FLUSH: if (r_flush_cnt == INDEX_W'(NUM_SETS - 1)) w_fsm_nxt = FSM_IDLE;
      default:   w_fsm_nxt = FSM_IDLE;
    endcase
  end

  // Sequencer state and flush set counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm       <= FSM_IDLE;
      r_flush_cnt <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (r_fsm == FSM_FLUSH) r_flush_cnt <= r_flush_cnt + 1'b1;
      else                    r_flush_cnt <= '0;
    end
  end

  // Update register: dropped while flushing or when a flush is requested
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd_v     <= 1'b0;
      r_upd_pc    <= '0;
      r_upd_tgt   <= '0;
      r_upd_taken <= 1'b0;
    end else begin
      r_upd_v <= upd_valid && w_idle && !flush_req;
      if (upd_valid) begin
        r_upd_pc    <= upd_pc[31:2];
        r_upd_tgt   <= upd_target;
        r_upd_taken <= upd_taken;
      end
    end
  end

  // Array and LRU writes; the update LRU write is last so it beats the lookup
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_way1 <= '{default: '0};
      r_way2 <= '{default: '0};
      r_lru  <= '0;
    end else if (r_fsm == FSM_FLUSH) begin
      r_way1[r_flush_cnt].valid <= 1'b0;
      r_way2[r_flush_cnt].valid <= 1'b0;
      r_lru[r_flush_cnt]        <= 1'b0;
    end else begin
      if (lookup_valid) r_lru[read_index] <= next_LRU_read;
      if (w_wr1)        r_way1[w_upd_idx] <= w_new1;
      if (w_wr2)        r_way2[w_upd_idx] <= w_new2;
      if (w_lru_we)     r_lru[w_upd_idx]  <= w_lru_bit;
    end
  end

  // Read port: array contents, optionally overlaid with the pending update
  always_comb begin
    w_rd1     = r_way1[read_index];
    w_rd2     = r_way2[read_index];
    w_lru_out = r_lru;
`ifdef BTB_WRITE_BYPASS_EN
    if (w_commit && (w_upd_idx == read_index)) begin
      if (w_wr1)    w_rd1 = w_new1;
      if (w_wr2)    w_rd2 = w_new2;
      if (w_lru_we) w_lru_out[w_upd_idx] = w_lru_bit;
    end
`endif
    read_set = (r_fsm == FSM_FLUSH) ? '0 : {w_rd1, w_rd2};
    lru      = w_lru_out;
  end

  assign busy = (r_fsm == FSM_FLUSH);

endmodule
